// File: rtl/cv32e40x_rvfi_trace_buffer_if.sv
// rtl/cv32e40x_rvfi_trace_buffer_if.sv - RVFI retire bus and trace read port
interface cv32e40x_rvfi_trace_buffer_if #(
  parameter int NRET    = 1,
  parameter int ENTRY_W = 109
);
  logic [NRET-1:0]    rvfi_valid;
  logic [32*NRET-1:0] rvfi_pc_rdata;
  logic [5*NRET-1:0]  rvfi_rd_addr;
  logic [32*NRET-1:0] rvfi_rd_wdata;
  logic [32*NRET-1:0] rvfi_mem_addr;
  logic [4*NRET-1:0]  rvfi_mem_rmask;
  logic [4*NRET-1:0]  rvfi_mem_wmask;
  logic               rd_ready_i;
  logic               rd_valid_o;
  logic [ENTRY_W-1:0] rd_data_o;

  modport master (
    output rvfi_valid, rvfi_pc_rdata, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rd_ready_i,
    input  rd_valid_o, rd_data_o
  );

  modport slave (
    input  rvfi_valid, rvfi_pc_rdata, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rd_ready_i,
    output rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/cv32e40x_rvfi_trace_buffer.sv
// rtl/cv32e40x_rvfi_trace_buffer.sv - multi-retire RVFI capture ring with PC trigger and freeze
// Optional: CV32E40X_TRACE_BUF_TIMESTAMP_EN appends a 32-bit cycle stamp to every entry.
module cv32e40x_rvfi_trace_buffer #(
  parameter int NRET      = 1,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  cv32e40x_rvfi_trace_buffer_if.slave bus,
  input  logic                       mode_overwrite_i,
  input  logic                       trig_en_i,
  input  logic [31:0]                trig_pc_i,
  input  logic                       clear_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [15:0]                drop_cnt_o,
  output logic                       frozen_o,
  output logic                       trig_hit_o
);
`ifdef CV32E40X_TRACE_BUF_TIMESTAMP_EN
  localparam int ENTRY_W = 141;
`else
  localparam int ENTRY_W = 109;
`endif
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = AW + 2;

  typedef enum logic [1:0] {S_CAPTURE, S_POST, S_FROZEN} state_t;

  state_t             r_state, w_state_nxt;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CNTW-1:0]    r_count, w_count_nxt;
  logic [15:0]        r_drop, w_drop_nxt;
  logic [16:0]        w_drop_sum;
  logic [CW-1:0]      r_post, w_post_nxt;
  logic               r_trig_hit, w_match, w_pop, w_take, w_in_post;
  logic [CW-1:0]      w_avail, w_budget, w_n_take, w_n_wr, w_n_post, w_n_post_wr;
  logic [CW-1:0]      w_fill, w_over, w_drops;
  logic [NRET-1:0]    w_wr_en;
  logic [AW-1:0]      w_wr_idx [NRET];
  logic [108:0]       w_fields [NRET];
  logic [ENTRY_W-1:0] w_entry  [NRET];
  int                 w_k;

`ifdef CV32E40X_TRACE_BUF_TIMESTAMP_EN
  logic [31:0] r_ts;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_ts <= '0;
    else       r_ts <= r_ts + 32'd1;
  end
`endif

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      w_fields[i] = {bus.rvfi_pc_rdata[32*i +: 32], bus.rvfi_rd_addr[5*i +: 5],
                     bus.rvfi_rd_wdata[32*i +: 32], bus.rvfi_mem_addr[32*i +: 32],
                     bus.rvfi_mem_rmask[4*i +: 4], bus.rvfi_mem_wmask[4*i +: 4]};
`ifdef CV32E40X_TRACE_BUF_TIMESTAMP_EN
      w_entry[i] = {w_fields[i], r_ts};
`else
      w_entry[i] = w_fields[i];
`endif
    end
  end

  always_comb begin
    w_pop   = (r_count != '0) && bus.rd_ready_i;
    w_avail = CW'(DEPTH) - CW'(r_count) + CW'(w_pop);
    w_match = 1'b0;
    w_k     = NRET;
    // Descending scan so the lowest matching channel is the one kept
    if (r_state == S_CAPTURE && trig_en_i) begin
      for (int i = NRET - 1; i >= 0; i--) begin
        if (bus.rvfi_valid[i] && bus.rvfi_pc_rdata[32*i +: 32] == trig_pc_i) begin
          w_match = 1'b1;
          w_k     = i;
        end
      end
    end
    w_budget    = w_match ? CW'(POST_TRIG) : ((r_state == S_POST) ? r_post : '0);
    w_n_take    = '0;
    w_n_wr      = '0;
    w_n_post    = '0;
    w_n_post_wr = '0;
    w_wr_en     = '0;
    w_take      = 1'b0;
    w_in_post   = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      w_wr_idx[i] = '0;
      w_take      = 1'b0;
      w_in_post   = 1'b0;
      if (bus.rvfi_valid[i]) begin
        if (r_state == S_CAPTURE && (!w_match || i <= w_k)) begin
          w_take = 1'b1;
        end else if (r_state != S_FROZEN && w_n_post < w_budget) begin
          w_take    = 1'b1;
          w_in_post = 1'b1;
        end
      end
      if (w_take) begin
        if (mode_overwrite_i || w_n_take < w_avail) begin
          w_wr_en[i]  = 1'b1;
          w_wr_idx[i] = r_wr_ptr + AW'(w_n_take);
          w_n_wr      = w_n_wr + CW'(1);
          if (w_in_post) w_n_post_wr = w_n_post_wr + CW'(1);
        end
        w_n_take = w_n_take + CW'(1);
        if (w_in_post) w_n_post = w_n_post + CW'(1);
      end
    end

    // Overwrite mode evicts the oldest entries that no longer fit
    w_fill       = CW'(r_count) - CW'(w_pop) + w_n_take;
    w_over       = (mode_overwrite_i && w_fill > CW'(DEPTH)) ? w_fill - CW'(DEPTH) : '0;
    w_drops      = mode_overwrite_i ? w_over : w_n_take - w_n_wr;
    w_count_nxt  = CNTW'(CW'(r_count) - CW'(w_pop) + w_n_wr - w_over);
    w_wr_ptr_nxt = r_wr_ptr + AW'(w_n_wr);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop) + AW'(w_over);
    w_drop_sum   = {1'b0, r_drop} + 17'(w_drops);
    w_drop_nxt   = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    w_state_nxt = r_state;
    w_post_nxt  = r_post;
    case (r_state)
      S_CAPTURE: begin
        if (w_match) begin
          w_post_nxt  = w_budget - w_n_post_wr;
          w_state_nxt = (w_post_nxt == '0) ? S_FROZEN : S_POST;
        end
      end
      S_POST: begin
        w_post_nxt = r_post - w_n_post_wr;
        if (w_post_nxt == '0) w_state_nxt = S_FROZEN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        r_state <= S_CAPTURE;
    else if (clear_i) r_state <= S_CAPTURE;
    else              r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop     <= '0;
      r_post     <= '0;
      r_trig_hit <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_drop     <= w_drop_nxt;
      r_post     <= w_post_nxt;
      r_trig_hit <= w_match;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++) begin
      if (!clear_i && w_wr_en[i]) r_mem[w_wr_idx[i]] <= w_entry[i];
    end
  end

  assign count_o        = r_count;
  assign drop_cnt_o     = r_drop;
  assign frozen_o       = (r_state == S_FROZEN);
  assign trig_hit_o     = r_trig_hit;
  assign bus.rd_valid_o = (r_count != '0);
  assign bus.rd_data_o  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
endmodule

// File: tb/tb_cv32e40x_rvfi_trace_buffer.sv
// tb/tb_cv32e40x_rvfi_trace_buffer.sv - directed and random checks against a queue model
module tb_cv32e40x_rvfi_trace_buffer;
  localparam int NRET      = 2;
  localparam int DEPTH     = 4;
  localparam int POST_TRIG = 1;
`ifdef CV32E40X_TRACE_BUF_TIMESTAMP_EN
  localparam int ENTRY_W = 141;
`else
  localparam int ENTRY_W = 109;
`endif
  localparam int CNTW   = $clog2(DEPTH) + 1;
  localparam int ST_CAP = 0;
  localparam int ST_PST = 1;
  localparam int ST_FRZ = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mode_ow, trig_en, clear;
  logic [31:0]     trig_pc;
  logic [CNTW-1:0] count;
  logic [15:0]     drop;
  logic            frozen, trig_hit;

  cv32e40x_rvfi_trace_buffer_if #(.NRET(NRET), .ENTRY_W(ENTRY_W)) bus ();

  cv32e40x_rvfi_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus),
    .mode_overwrite_i(mode_ow),
    .trig_en_i       (trig_en),
    .trig_pc_i       (trig_pc),
    .clear_i         (clear),
    .count_o         (count),
    .drop_cnt_o      (drop),
    .frozen_o        (frozen),
    .trig_hit_o      (trig_hit)
  );

  always #5 clk = ~clk;

  int                 n_tests = 0;
  int                 n_fail  = 0;
  logic [ENTRY_W-1:0] m_q[$];
  int                 m_drop, m_state, m_post, m_hit;
  logic [31:0]        m_ts;

  task automatic check(string tag, logic [159:0] got, logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_drop  = 0;
    m_state = ST_CAP;
    m_post  = 0;
    m_hit   = 0;
    m_ts    = '0;
  endtask

  function automatic logic [ENTRY_W-1:0] mk_entry(int ch);
    logic [108:0] f;
    f = {bus.rvfi_pc_rdata[32*ch +: 32], bus.rvfi_rd_addr[5*ch +: 5],
         bus.rvfi_rd_wdata[32*ch +: 32], bus.rvfi_mem_addr[32*ch +: 32],
         bus.rvfi_mem_rmask[4*ch +: 4], bus.rvfi_mem_wmask[4*ch +: 4]};
`ifdef CV32E40X_TRACE_BUF_TIMESTAMP_EN
    return {f, m_ts};
`else
    return f;
`endif
  endfunction

  task automatic bump_drop();
    if (m_drop < 65535) m_drop++;
  endtask

  // One clock edge of the reference: pop, pick accepted retires, then push with stop/overwrite rules
  task automatic model_step();
    logic [ENTRY_W-1:0] acc[$];
    bit                 accp[$];
    bit                 matched, wr;
    int                 budget, npost;
    matched = 0;
    budget  = 0;
    npost   = 0;
    if (clear) begin
      m_q.delete();
      m_drop  = 0;
      m_state = ST_CAP;
      m_post  = 0;
      m_hit   = 0;
      m_ts    = m_ts + 1;
      return;
    end
    if (m_q.size() != 0 && bus.rd_ready_i) void'(m_q.pop_front());
    if (m_state == ST_PST) budget = m_post;
    for (int ch = 0; ch < NRET; ch++) begin
      if (bus.rvfi_valid[ch]) begin
        if (m_state == ST_CAP && !matched) begin
          acc.push_back(mk_entry(ch));
          accp.push_back(1'b0);
          if (trig_en && bus.rvfi_pc_rdata[32*ch +: 32] == trig_pc) begin
            matched = 1;
            budget  = POST_TRIG;
            m_post  = POST_TRIG;
          end
        end else if (m_state != ST_FRZ && npost < budget) begin
          acc.push_back(mk_entry(ch));
          accp.push_back(1'b1);
          npost++;
        end
      end
    end
    m_hit = matched;
    foreach (acc[j]) begin
      wr = 1;
      if (m_q.size() == DEPTH) begin
        bump_drop();
        if (mode_ow) void'(m_q.pop_front());
        else wr = 0;
      end
      if (wr) begin
        m_q.push_back(acc[j]);
        if (accp[j]) m_post--;
      end
    end
    if (matched || m_state == ST_PST) begin
      if (m_post == 0) m_state = ST_FRZ;
      else if (matched) m_state = ST_PST;
    end
    m_ts = m_ts + 1;
  endtask

  task automatic compare_all();
    logic [ENTRY_W-1:0] head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    check("count",    count, m_q.size());
    check("rd_valid", bus.rd_valid_o, m_q.size() != 0);
    check("rd_data",  bus.rd_data_o, head);
    check("drop",     drop, m_drop);
    check("frozen",   frozen, m_state == ST_FRZ);
    check("trig_hit", trig_hit, m_hit);
  endtask

  task automatic set_in(logic [1:0] v, logic [31:0] pc0, logic [31:0] pc1, logic rdy);
    bus.rvfi_valid     = v;
    bus.rvfi_pc_rdata  = {pc1, pc0};
    bus.rvfi_rd_addr   = 10'($urandom);
    bus.rvfi_rd_wdata  = {$urandom, $urandom};
    bus.rvfi_mem_addr  = {$urandom, $urandom};
    bus.rvfi_mem_rmask = 8'($urandom);
    bus.rvfi_mem_wmask = 8'($urandom);
    bus.rd_ready_i     = rdy;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    set_in(2'b00, '0, '0, 1'b0);
    tick();
    clear = 1'b0;
  endtask

  initial begin
    mode_ow = 1'b0;
    trig_en = 1'b0;
    trig_pc = '0;
    clear   = 1'b0;
    set_in(2'b00, '0, '0, 1'b0);
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_all();

    // Stop mode fill: three double retires into four slots
    for (int c = 0; c < 3; c++) begin
      set_in(2'b11, 32'h100 + 8*c, 32'h104 + 8*c, 1'b0);
      tick();
    end
    check("stop_count", count, 4);
    check("stop_drop", drop, 2);
    check("stop_head_pc", bus.rd_data_o[ENTRY_W-1 -: 32], 32'h100);
    set_in(2'b01, 32'h300, 32'h0, 1'b1);
    tick();
    check("full_pop_push_count", count, 4);
    check("full_pop_push_drop", drop, 2);
    for (int c = 0; c < 3; c++) begin
      check("stop_order_pc", bus.rd_data_o[ENTRY_W-1 -: 32], 32'h104 + 4*c);
      set_in(2'b00, '0, '0, 1'b1);
      tick();
    end
    check("stop_last_pc", bus.rd_data_o[ENTRY_W-1 -: 32], 32'h300);
    do_clear();
    check("clear_count", count, 0);
    check("clear_drop", drop, 0);

    // Overwrite mode: six single retires
    mode_ow = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_in(2'b01, 32'h100 + 4*c, 32'h0, 1'b0);
      tick();
    end
    check("ow_count", count, 4);
    check("ow_drop", drop, 2);
    for (int c = 0; c < 4; c++) begin
      check("ow_order_pc", bus.rd_data_o[ENTRY_W-1 -: 32], 32'h108 + 4*c);
      set_in(2'b00, '0, '0, 1'b1);
      tick();
    end
    mode_ow = 1'b0;
    do_clear();

    // Only channel 1 valid
    set_in(2'b10, 32'h400, 32'h404, 1'b0);
    tick();
    check("ch1_count", count, 1);
    check("ch1_pc", bus.rd_data_o[ENTRY_W-1 -: 32], 32'h404);
    do_clear();

    // Trigger on channel 0 with one post entry, then freeze and clear
    set_in(2'b01, 32'h1FC, 32'h0, 1'b0);
    tick();
    trig_en = 1'b1;
    trig_pc = 32'h200;
    set_in(2'b11, 32'h200, 32'h204, 1'b0);
    tick();
    check("trig_hit_pulse", trig_hit, 1);
    check("trig_frozen", frozen, 1);
    check("trig_count", count, 3);
    set_in(2'b11, 32'h200, 32'h20C, 1'b0);
    tick();
    check("trig_hit_drop", trig_hit, 0);
    check("frozen_ignores", count, 3);
    do_clear();
    check("unfreeze_count", count, 0);
    check("unfreeze_frozen", frozen, 0);
    check("unfreeze_drop", drop, 0);
    trig_en = 1'b0;

    // Async reset in the middle of a burst
    for (int c = 0; c < 3; c++) begin
      set_in(2'b11, 32'h500 + 8*c, 32'h504 + 8*c, 1'b0);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_drop", drop, 0);
    check("arst_valid", bus.rd_valid_o, 0);
    check("arst_frozen", frozen, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // Random traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 0) mode_ow = 1'($urandom_range(0, 1));
      trig_en = ($urandom_range(0, 5) == 0);
      trig_pc = 32'h200 + 4*$urandom_range(0, 7);
      clear   = ($urandom_range(0, 39) == 0);
      set_in(2'($urandom), 32'h200 + 4*$urandom_range(0, 7),
             32'h200 + 4*$urandom_range(0, 7), 1'($urandom_range(0, 1)));
      tick();
    end
    clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
